// File: rtl/mem_pkg.sv
// Shared decode constants, state type and store-lane helpers for the memory stage.
package mem_pkg;

  // Major opcodes taken from instr[6:2]
  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;

  // funct3 encodings for loads and stores
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // addi x0,x0,0: harmless bubble for writeback
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h00000013;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Access size comes from funct3[1:0]: 00 byte, 01 half, anything else word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return (off != 2'b00);
    endcase
  endfunction

  // Byte enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the store operand across every lane so the strobes pick the right one.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: picks the addressed lane of a bus word and extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  byte_lanes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign byte_lanes[gi] = rdata[8*gi +: 8];
  end

  // Select the addressed byte/halfword and apply sign or zero extension
  always_comb begin
    byte_sel = byte_lanes[offset];
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   value = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   value = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  value = {24'h0, byte_sel};
      F3_LHU:  value = {16'h0, half_sel};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// RV32I data-memory stage: runs loads/stores over a req/ack bus and hands a
// registered bundle to writeback, stalling execute while an access is pending.
module memory_stage
  import mem_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter logic [31:0] NOP_INSTR   = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] EXECUTE_IN,
  input  logic [31:0] EXECUTE_STORE_DATA,
  input  logic        EXECUTE_VALID,
  output logic        MEMORY_STALL,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] MEMORY_OUT,
  output logic [31:0] MEMORY_INSTR_OUT,
  output logic [31:0] MEMORY_PC_OUT,
  output logic        MEMORY_VALID,
  output logic        MEMORY_ERR
);

  // Wide enough to hold ACK_TIMEOUT-1; a timeout of 0 disables the check entirely.
  localparam int unsigned     CNT_W    = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_e            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              req_reg, req_next;
  logic              we_reg, we_next;
  logic [31:0]       addr_reg, addr_next;
  logic [3:0]        wstrb_reg, wstrb_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [31:0]       out_reg, out_next;
  logic [31:0]       instr_out_reg, instr_out_next;
  logic [31:0]       pc_out_reg, pc_out_next;
  logic              valid_reg, valid_next;
  logic              err_reg, err_next;
  logic [31:0]       busy_instr_reg, busy_instr_next;
  logic [31:0]       busy_pc_reg, busy_pc_next;
  logic [1:0]        busy_off_reg, busy_off_next;

  logic [4:0]  opcode;
  logic [1:0]  size;
  logic [1:0]  offset;
  logic        is_load;
  logic        is_store;
  logic [31:0] load_value;

  assign opcode   = instr[6:2];
  assign size     = instr[13:12];
  assign offset   = EXECUTE_IN[1:0];
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);

  // The lane selection uses the latched offset/funct3 of the outstanding load
  load_align u_load_align (
    .rdata  (dmem_rdata),
    .offset (busy_off_reg),
    .funct3 (busy_instr_reg[14:12]),
    .value  (load_value)
  );

  assign MEMORY_STALL     = (state_reg != IDLE);
  assign dmem_req         = req_reg;
  assign dmem_we          = we_reg;
  assign dmem_addr        = addr_reg;
  assign dmem_wstrb       = wstrb_reg;
  assign dmem_wdata       = wdata_reg;
  assign MEMORY_OUT       = out_reg;
  assign MEMORY_INSTR_OUT = instr_out_reg;
  assign MEMORY_PC_OUT    = pc_out_reg;
  assign MEMORY_VALID     = valid_reg;
  assign MEMORY_ERR       = err_reg;

  // Next-state and next-output logic; output pulses default low, instr defaults to bubble
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    req_next        = req_reg;
    we_next         = we_reg;
    addr_next       = addr_reg;
    wstrb_next      = wstrb_reg;
    wdata_next      = wdata_reg;
    out_next        = out_reg;
    instr_out_next  = NOP_INSTR;
    pc_out_next     = pc_out_reg;
    valid_next      = 1'b0;
    err_next        = 1'b0;
    busy_instr_next = busy_instr_reg;
    busy_pc_next    = busy_pc_reg;
    busy_off_next   = busy_off_reg;

    case (state_reg)
      IDLE: begin
        if (EXECUTE_VALID) begin
          if (!is_load && !is_store) begin
            // ALU result passes straight through in one cycle
            out_next       = EXECUTE_IN;
            instr_out_next = instr;
            pc_out_next    = pc;
            valid_next     = 1'b1;
          end else if (is_misaligned(size, offset)) begin
            // Never touches the bus; instruction is killed and flagged
            out_next    = 32'h0;
            pc_out_next = pc;
            valid_next  = 1'b1;
            err_next    = 1'b1;
          end else begin
            state_next      = BUSY;
            cnt_next        = '0;
            req_next        = 1'b1;
            we_next         = is_store;
            addr_next       = {EXECUTE_IN[31:2], 2'b00};
            wstrb_next      = is_store ? store_strb(size, offset) : 4'b0000;
            wdata_next      = is_store ? store_lanes(size, EXECUTE_STORE_DATA) : 32'h0;
            busy_instr_next = instr;
            busy_pc_next    = pc;
            busy_off_next   = offset;
          end
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          // Ack beats a coincident timeout
          state_next     = IDLE;
          req_next       = 1'b0;
          out_next       = we_reg ? 32'h0 : load_value;
          instr_out_next = busy_instr_reg;
          pc_out_next    = busy_pc_reg;
          valid_next     = 1'b1;
        end else if ((ACK_TIMEOUT != 0) && (cnt_reg == CNT_LAST)) begin
          state_next  = IDLE;
          req_next    = 1'b0;
          out_next    = 32'h0;
          pc_out_next = busy_pc_reg;
          valid_next  = 1'b1;
          err_next    = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers; reset abandons any pending access silently
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      req_reg        <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= 32'h0;
      wstrb_reg      <= 4'b0000;
      wdata_reg      <= 32'h0;
      out_reg        <= 32'h0;
      instr_out_reg  <= NOP_INSTR;
      pc_out_reg     <= 32'h0;
      valid_reg      <= 1'b0;
      err_reg        <= 1'b0;
      busy_instr_reg <= NOP_INSTR;
      busy_pc_reg    <= 32'h0;
      busy_off_reg   <= 2'b00;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      req_reg        <= req_next;
      we_reg         <= we_next;
      addr_reg       <= addr_next;
      wstrb_reg      <= wstrb_next;
      wdata_reg      <= wdata_next;
      out_reg        <= out_next;
      instr_out_reg  <= instr_out_next;
      pc_out_reg     <= pc_out_next;
      valid_reg      <= valid_next;
      err_reg        <= err_next;
      busy_instr_reg <= busy_instr_next;
      busy_pc_reg    <= busy_pc_next;
      busy_off_reg   <= busy_off_next;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios plus random bundles against a behavioural model.
module tb_memory_stage;

  localparam int          TMO = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, pc, execute_in, store_data, dmem_rdata;
  logic        execute_valid, dmem_ack;
  logic        mem_stall, dmem_req, dmem_we, mem_valid, mem_err;
  logic [31:0] dmem_addr, dmem_wdata, mem_out, mem_instr, mem_pc;
  logic [3:0]  dmem_wstrb;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  memory_stage #(.ACK_TIMEOUT(TMO), .NOP_INSTR(NOP)) dut (
    .clk                (clk),
    .rst                (rst),
    .instr              (instr),
    .pc                 (pc),
    .EXECUTE_IN         (execute_in),
    .EXECUTE_STORE_DATA (store_data),
    .EXECUTE_VALID      (execute_valid),
    .MEMORY_STALL       (mem_stall),
    .dmem_req           (dmem_req),
    .dmem_we            (dmem_we),
    .dmem_addr          (dmem_addr),
    .dmem_wstrb         (dmem_wstrb),
    .dmem_wdata         (dmem_wdata),
    .dmem_rdata         (dmem_rdata),
    .dmem_ack           (dmem_ack),
    .MEMORY_OUT         (mem_out),
    .MEMORY_INSTR_OUT   (mem_instr),
    .MEMORY_PC_OUT      (mem_pc),
    .MEMORY_VALID       (mem_valid),
    .MEMORY_ERR         (mem_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bundle end to end; t_delay = BUSY cycle in which ack arrives, 0 = never
  task automatic do_txn(input logic [31:0] t_instr, input logic [31:0] t_pc,
                        input logic [31:0] t_addr, input logic [31:0] t_sdata,
                        input logic [31:0] t_rdata, input int t_delay);
    logic [4:0]  op;
    logic [2:0]  f3;
    int          size, off;
    bit          is_ld, is_st, mis, done;
    logic [31:0] lane, exp_out, exp_wdata, exp_addr;
    logic [3:0]  exp_strb;
    op    = t_instr[6:2];
    f3    = t_instr[14:12];
    off   = int'(t_addr[1:0]);
    is_ld = (op == 5'b00000);
    is_st = (op == 5'b01000);
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    mis   = (is_ld || is_st) && ((off % size) != 0);
    exp_addr = t_addr & 32'hFFFF_FFFC;
    lane = t_rdata >> (8 * off);
    if (size == 1) begin
      exp_out = lane & 32'hFF;
      if (!f3[2] && exp_out >= 32'h80) exp_out = exp_out - 32'h100;
    end else if (size == 2) begin
      exp_out = lane & 32'hFFFF;
      if (!f3[2] && exp_out >= 32'h8000) exp_out = exp_out - 32'h10000;
    end else begin
      exp_out = t_rdata;
    end
    if (is_st) exp_out = 32'h0;
    exp_strb  = is_st ? 4'(((1 << size) - 1) << off) : 4'b0000;
    exp_wdata = (size == 1) ? (t_sdata & 32'hFF) * 32'h01010101 :
                (size == 2) ? (t_sdata & 32'hFFFF) * 32'h00010001 : t_sdata;

    instr = t_instr; pc = t_pc; execute_in = t_addr; store_data = t_sdata;
    execute_valid = 1'b1;
    vectors++;
    if (mem_stall !== 1'b0) begin
      miscompares++; $display("FAIL accept_stall: got %b want 0", mem_stall);
    end
    tick();
    if (!is_ld && !is_st) begin
      execute_valid = 1'b0;
      vectors++;
      if ({mem_valid, mem_err, dmem_req, mem_stall} !== 4'b1000) begin
        miscompares++; $display("FAIL alu_flags: got %b want 1000", {mem_valid, mem_err, dmem_req, mem_stall});
      end
      vectors++;
      if (mem_out !== t_addr || mem_instr !== t_instr || mem_pc !== t_pc) begin
        miscompares++; $display("FAIL alu_bundle: got %h/%h/%h want %h/%h/%h", mem_out, mem_instr, mem_pc, t_addr, t_instr, t_pc);
      end
      $display("txn alu   instr=%h out=%h", t_instr, mem_out);
    end else if (mis) begin
      execute_valid = 1'b0;
      vectors++;
      if ({mem_valid, mem_err, dmem_req, mem_stall} !== 4'b1100) begin
        miscompares++; $display("FAIL misalign_flags: got %b want 1100", {mem_valid, mem_err, dmem_req, mem_stall});
      end
      vectors++;
      if (mem_out !== 32'h0 || mem_instr !== NOP || mem_pc !== t_pc) begin
        miscompares++; $display("FAIL misalign_bundle: got %h/%h/%h want 0/%h/%h", mem_out, mem_instr, mem_pc, NOP, t_pc);
      end
      $display("txn misal instr=%h addr=%h err=%b", t_instr, t_addr, mem_err);
    end else begin
      vectors++;
      if ({mem_valid, mem_err, dmem_req, mem_stall} !== 4'b0011 || mem_instr !== NOP) begin
        miscompares++; $display("FAIL req_flags: got %b instr=%h want 0011 instr=%h", {mem_valid, mem_err, dmem_req, mem_stall}, mem_instr, NOP);
      end
      vectors++;
      if (dmem_we !== is_st || dmem_addr !== exp_addr || dmem_wstrb !== exp_strb) begin
        miscompares++; $display("FAIL req_bus: got we=%b addr=%h strb=%b want we=%b addr=%h strb=%b", dmem_we, dmem_addr, dmem_wstrb, is_st, exp_addr, exp_strb);
      end
      if (is_st) begin
        vectors++;
        if (dmem_wdata !== exp_wdata) begin
          miscompares++; $display("FAIL req_wdata: got %h want %h", dmem_wdata, exp_wdata);
        end
      end
      done = 1'b0;
      for (int k = 1; k <= TMO && !done; k++) begin
        if (k == t_delay) begin
          dmem_ack = 1'b1; dmem_rdata = t_rdata;
        end else begin
          dmem_rdata = $urandom;
        end
        tick();
        dmem_ack = 1'b0;
        if (k == t_delay) begin
          execute_valid = 1'b0; done = 1'b1;
          vectors++;
          if ({mem_valid, mem_err, dmem_req, mem_stall} !== 4'b1000) begin
            miscompares++; $display("FAIL done_flags: got %b want 1000", {mem_valid, mem_err, dmem_req, mem_stall});
          end
          vectors++;
          if (mem_out !== exp_out || mem_instr !== t_instr || mem_pc !== t_pc) begin
            miscompares++; $display("FAIL done_bundle: got %h/%h/%h want %h/%h/%h", mem_out, mem_instr, mem_pc, exp_out, t_instr, t_pc);
          end
          $display("txn mem   instr=%h addr=%h ack@%0d out=%h", t_instr, t_addr, k, mem_out);
        end else if (k == TMO) begin
          execute_valid = 1'b0; done = 1'b1;
          vectors++;
          if ({mem_valid, mem_err, dmem_req, mem_stall} !== 4'b1100) begin
            miscompares++; $display("FAIL timeout_flags: got %b want 1100", {mem_valid, mem_err, dmem_req, mem_stall});
          end
          vectors++;
          if (mem_out !== 32'h0 || mem_instr !== NOP || mem_pc !== t_pc) begin
            miscompares++; $display("FAIL timeout_bundle: got %h/%h/%h want 0/%h/%h", mem_out, mem_instr, mem_pc, NOP, t_pc);
          end
          $display("txn tmo   instr=%h addr=%h err=%b", t_instr, t_addr, mem_err);
        end else begin
          vectors++;
          if ({mem_valid, dmem_req, mem_stall} !== 3'b011 || dmem_addr !== exp_addr || dmem_wstrb !== exp_strb) begin
            miscompares++; $display("FAIL busy_hold: got %b addr=%h strb=%b want 011 addr=%h strb=%b", {mem_valid, dmem_req, mem_stall}, dmem_addr, dmem_wstrb, exp_addr, exp_strb);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; execute_valid = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    instr = NOP; pc = 32'h0; execute_in = 32'h0; store_data = 32'h0;
    tick(); tick();
    vectors++;
    if ({dmem_req, dmem_we, dmem_wstrb, mem_valid, mem_err, mem_stall} !== 9'b0) begin
      miscompares++; $display("FAIL reset_flags: got %b want 0", {dmem_req, dmem_we, dmem_wstrb, mem_valid, mem_err, mem_stall});
    end
    vectors++;
    if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || mem_out !== 32'h0 || mem_pc !== 32'h0) begin
      miscompares++; $display("FAIL reset_data: got %h/%h/%h/%h want zeros", dmem_addr, dmem_wdata, mem_out, mem_pc);
    end
    vectors++;
    if (mem_instr !== NOP) begin
      miscompares++; $display("FAIL reset_instr: got %h want %h", mem_instr, NOP);
    end
    rst = 1'b0;
    $display("txn reset done");
  endtask

  task automatic test_directed();
    do_txn(32'h00A00093, 32'h0000_0100, 32'd10, 32'h0, 32'h0, 1);           // addi
    do_txn(32'h00008083, 32'h0000_0104, 32'h1003, 32'h0, 32'h80FFFFFF, 4);  // lb, ack ties timeout
    do_txn(32'h0000C083, 32'h0000_0108, 32'h1003, 32'h0, 32'h80FFFFFF, 4);  // lbu
    do_txn(32'h00209023, 32'h0000_010C, 32'h2002, 32'h1234ABCD, 32'h0, 2);  // sh
    do_txn(32'h0000A083, 32'h0000_0110, 32'h3001, 32'h0, 32'h0, 1);         // lw misaligned
  endtask

  task automatic test_timeout();
    do_txn(32'h0000A083, 32'h0000_0200, 32'h4000, 32'h0, 32'h0, 0);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    tick();
    dmem_ack = 1'b0;
    vectors++;
    if ({mem_valid, mem_err, dmem_req, mem_stall} !== 4'b0000 || mem_instr !== NOP) begin
      miscompares++; $display("FAIL late_ack: got %b instr=%h want 0000 instr=%h", {mem_valid, mem_err, dmem_req, mem_stall}, mem_instr, NOP);
    end
    $display("txn late ack ignored");
  endtask

  task automatic test_reset_mid();
    instr = 32'h0000A083; pc = 32'h300; execute_in = 32'h100; execute_valid = 1'b1;
    tick();
    vectors++;
    if (dmem_req !== 1'b1) begin
      miscompares++; $display("FAIL midrst_req: got %b want 1", dmem_req);
    end
    tick();
    rst = 1'b1; execute_valid = 1'b0;
    tick();
    rst = 1'b0;
    vectors++;
    if ({mem_valid, mem_err, dmem_req, mem_stall} !== 4'b0000 || mem_instr !== NOP || mem_out !== 32'h0 || mem_pc !== 32'h0) begin
      miscompares++; $display("FAIL midrst_state: got %b %h/%h/%h want 0000 %h/0/0", {mem_valid, mem_err, dmem_req, mem_stall}, mem_instr, mem_out, mem_pc, NOP);
    end
    $display("txn reset mid-access");
    do_txn(32'h0000A083, 32'h0000_0304, 32'h0, 32'h0, 32'hCAFEF00D, 1);
  endtask

  task automatic test_random();
    logic [31:0] r, t_instr;
    logic [4:0]  op;
    logic [2:0]  f3;
    int          cls, dly;
    logic [2:0]  ld_f3 [5];
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 40; i++) begin
      cls = int'($urandom_range(0, 2));
      r   = $urandom;
      if (cls == 0) begin
        op = 5'($urandom_range(0, 31));
        if (op == 5'b00000 || op == 5'b01000) op = 5'b00100;
        f3 = r[14:12];
      end else if (cls == 1) begin
        op = 5'b00000;
        f3 = ld_f3[$urandom_range(0, 4)];
      end else begin
        op = 5'b01000;
        f3 = 3'($urandom_range(0, 2));
      end
      t_instr = {r[31:15], f3, r[11:7], op, 2'b11};
      dly = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TMO));
      do_txn(t_instr, $urandom, $urandom, $urandom, $urandom, dly);
      if ($urandom_range(0, 1) == 1) begin
        tick();
        vectors++;
        if ({mem_valid, mem_err} !== 2'b00 || mem_instr !== NOP) begin
          miscompares++; $display("FAIL pulse_width: got %b instr=%h want 00 instr=%h", {mem_valid, mem_err}, mem_instr, NOP);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
